// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - program counter and IF/ID stage feeding decode
// Handles PC increment with wrap, branch redirect with flush, sticky fetch error and handshake count.
module instruction_fetch_unit #(
    parameter logic [63:0] RESET_PC   = 64'd0,
    parameter logic [63:0] IMEM_BYTES = 64'd16,
    parameter logic [31:0] NOP_INSN   = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] Inst_Addr,
    input  logic [31:0] Instruction,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    input  logic        if_ready,
    output logic        if_valid,
    output logic [63:0] if_pc,
    output logic [31:0] if_instruction,
    output logic        fetch_error,
    output logic [31:0] fetch_count
);

    logic [63:0] pc_q, pc_d;
    logic        if_valid_q, if_valid_d;
    logic [63:0] if_pc_q, if_pc_d;
    logic [31:0] if_instruction_q, if_instruction_d;
    logic        fetch_error_q, fetch_error_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic        load;
    logic        handshake;
    logic [63:0] pc_inc;
    logic [63:0] next_pc;
    logic [63:0] target;

    always_comb begin
        load      = ~if_valid_q | if_ready;
        handshake = if_valid_q & if_ready;
        pc_inc    = pc_q + 64'd4;
        next_pc   = (pc_inc >= IMEM_BYTES) ? RESET_PC : pc_inc;
        target    = branch_target & ~64'd3;

        pc_d             = pc_q;
        if_valid_d       = if_valid_q;
        if_pc_d          = if_pc_q;
        if_instruction_d = if_instruction_q;
        fetch_error_d    = fetch_error_q;
        fetch_count_d    = fetch_count_q;

        // The handshake is counted even when a redirect flushes IF/ID on the same edge.
        if (handshake && (fetch_count_q != 32'hFFFF_FFFF)) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end

        if (branch_taken) begin
            if_valid_d       = 1'b0;
            if_instruction_d = NOP_INSN;
            if_pc_d          = target;
            if (target >= IMEM_BYTES) begin
                pc_d          = RESET_PC;
                fetch_error_d = 1'b1;
            end else begin
                pc_d = target;
            end
        end else if (load) begin
            if_valid_d       = 1'b1;
            if_pc_d          = pc_q;
            if_instruction_d = Instruction;
            pc_d             = next_pc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q             <= RESET_PC;
            if_valid_q       <= 1'b0;
            if_pc_q          <= 64'd0;
            if_instruction_q <= NOP_INSN;
            fetch_error_q    <= 1'b0;
            fetch_count_q    <= 32'd0;
        end else begin
            pc_q             <= pc_d;
            if_valid_q       <= if_valid_d;
            if_pc_q          <= if_pc_d;
            if_instruction_q <= if_instruction_d;
            fetch_error_q    <= fetch_error_d;
            fetch_count_q    <= fetch_count_d;
        end
    end

    assign Inst_Addr      = pc_q;
    assign if_valid       = if_valid_q;
    assign if_pc          = if_pc_q;
    assign if_instruction = if_instruction_q;
    assign fetch_error    = fetch_error_q;
    assign fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - scoreboard bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

    localparam logic [63:0] IMEM_BYTES = 64'd16;
    localparam logic [31:0] NOP        = 32'h00000013;

    logic        clk;
    logic        reset;
    logic [63:0] Inst_Addr;
    logic [31:0] Instruction;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic        if_ready;
    logic        if_valid;
    logic [63:0] if_pc;
    logic [31:0] if_instruction;
    logic        fetch_error;
    logic [31:0] fetch_count;

    logic [31:0] mem [4];

    int checks;
    int failures;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] insn;
    } fetch_t;
    fetch_t sb_q[$];

    logic        mdl_valid;
    logic [63:0] mdl_pc;
    logic [63:0] cur_pc;
    logic [31:0] cur_insn;
    logic        mdl_err;
    logic [31:0] mdl_count;
    logic        mdl_loaded;

    instruction_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .Inst_Addr      (Inst_Addr),
        .Instruction    (Instruction),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .if_ready       (if_ready),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instruction (if_instruction),
        .fetch_error    (fetch_error),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        Instruction = 32'h0;
        if (Inst_Addr < IMEM_BYTES) Instruction = mem[Inst_Addr[3:2]];
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb_q.delete();
        mdl_valid = 1'b0;
        mdl_pc    = 64'd0;
        cur_pc    = 64'd0;
        cur_insn  = NOP;
        mdl_err   = 1'b0;
        mdl_count = 32'd0;
    endtask

    // Advance one clock; the model is updated from the inputs as they stand before the edge.
    task automatic tick();
        logic [63:0] t;
        fetch_t f;
        mdl_loaded = 1'b0;
        if (mdl_valid && if_ready && mdl_count != 32'hFFFF_FFFF) mdl_count = mdl_count + 32'd1;
        if (branch_taken) begin
            t         = {branch_target[63:2], 2'b00};
            mdl_valid = 1'b0;
            cur_pc    = t;
            cur_insn  = NOP;
            if (t >= IMEM_BYTES) begin
                mdl_pc  = 64'd0;
                mdl_err = 1'b1;
            end else begin
                mdl_pc = t;
            end
        end else if (!mdl_valid || if_ready) begin
            f.pc   = mdl_pc;
            f.insn = mem[mdl_pc[3:2]];
            sb_q.push_back(f);
            mdl_valid  = 1'b1;
            mdl_loaded = 1'b1;
            mdl_pc     = (mdl_pc + 64'd4 >= IMEM_BYTES) ? 64'd0 : mdl_pc + 64'd4;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_state(input string tag);
        fetch_t f;
        if (mdl_loaded) begin
            if (sb_q.size() == 0) begin
                check_eq({tag, "_sb_empty"}, 64'd1, 64'd0);
            end else begin
                f        = sb_q.pop_front();
                cur_pc   = f.pc;
                cur_insn = f.insn;
            end
        end
        check_eq({tag, "_valid"}, {63'd0, if_valid}, {63'd0, mdl_valid});
        check_eq({tag, "_if_pc"}, if_pc, cur_pc);
        check_eq({tag, "_insn"}, {32'd0, if_instruction}, {32'd0, cur_insn});
        check_eq({tag, "_addr"}, Inst_Addr, mdl_pc);
        check_eq({tag, "_err"}, {63'd0, fetch_error}, {63'd0, mdl_err});
        check_eq({tag, "_count"}, {32'd0, fetch_count}, {32'd0, mdl_count});
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        mem[0] = 32'h0F053483;
        mem[1] = 32'h009A84B3;
        mem[2] = 32'h00148493;
        mem[3] = 32'h0E953823;
        reset         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 64'd0;
        if_ready      = 1'b1;
        model_reset();

        @(negedge clk);
        @(negedge clk);
        mdl_loaded = 1'b0;
        check_state("reset");

        // Free-run with wrap: 0,4,8,12,0 then 4 completes the fifth handshake
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_state("run");
        end
        check_eq("run_count5", {32'd0, fetch_count}, 64'd5);

        // Stall at pc 4 for three cycles
        if_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_state("stall");
        end
        check_eq("stall_pc4", if_pc, 64'd4);
        if_ready = 1'b1;
        tick();
        check_state("unstall");
        check_eq("unstall_pc8", if_pc, 64'd8);

        // Misaligned redirect to 11 while stalled: PC becomes 8, IF/ID flushed
        if_ready      = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 64'd11;
        tick();
        branch_taken = 1'b0;
        check_state("br11");
        check_eq("br11_addr8", Inst_Addr, 64'd8);
        if_ready = 1'b1;
        tick();
        check_state("br11_next");

        // Redirect coinciding with a handshake still counts it
        branch_taken  = 1'b1;
        branch_target = 64'd12;
        tick();
        branch_taken = 1'b0;
        check_state("br12_hs");

        // Out-of-range redirect sets the sticky error, then 20 more cycles
        branch_taken  = 1'b1;
        branch_target = 64'd40;
        tick();
        branch_taken = 1'b0;
        check_state("br40");
        for (int i = 0; i < 20; i++) begin
            tick();
            check_state("sticky");
        end

        // Run until IF/ID holds pc 12, then assert reset between edges
        for (int i = 0; i < 8 && !(if_valid && if_pc == 64'd12); i++) tick();
        check_eq("pre_rst_pc12", if_pc, 64'd12);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        mdl_loaded = 1'b0;
        check_state("async_rst");
        @(negedge clk);
        check_state("rst_hold");
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_state("restart");
        end

        // Saturation of the handshake counter
        force dut.fetch_count_q = 32'hFFFF_FFFE;
        #1;
        release dut.fetch_count_q;
        mdl_count = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_state("sat");
        end
        check_eq("sat_final", {32'd0, fetch_count}, 64'hFFFF_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
